mc_ctrl_fsm: RTL and testbench

//  Multi-cycle control FSM for the RV32I core. Sequences fetch/decode/execute/memory/writeback.

---
 rtl/mc_ctrl_fsm_pkg.sv | 106 ++++++++++
 rtl/mc_ctrl_fsm_if.sv | 33 +++
 rtl/mc_ctrl_fsm_decode.sv | 37 +++
 rtl/mc_ctrl_fsm.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm_pkg
// Shared types for the multi-cycle RV32I control FSM: opcode constants, the
// controller state and instruction-class enums, datapath select encodings and
// a helper that maps an instruction class onto its EXEC operand selects.
// -----------------------------------------------------------------------------
package mc_ctrl_fsm_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CLS_OP     = 4'd0,
        CLS_OPIMM  = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_LUI    = 4'd5,
        CLS_AUIPC  = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8
    } class_t;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_ALU   = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_FUNCT = 2'd1,
        ALU_CMP   = 2'd2,
        ALU_PASSB = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    // Operand selects used from EXEC through the end of the instruction
    typedef struct packed {
        logic    alu_a_sel;
        logic    alu_b_sel;
        alu_op_t alu_op;
    } sel_t;

    // Map an instruction class to the ALU operand/operation selects
    function automatic sel_t exec_sel(input class_t cls);
        sel_t s;
        s.alu_a_sel = 1'b0;
        s.alu_b_sel = 1'b0;
        s.alu_op    = ALU_ADD;
        case (cls)
            CLS_OP: begin
                s.alu_op    = ALU_FUNCT;
            end
            CLS_OPIMM: begin
                s.alu_b_sel = 1'b1;
                s.alu_op    = ALU_FUNCT;
            end
            CLS_LOAD, CLS_STORE, CLS_JALR: begin
                s.alu_b_sel = 1'b1;
                s.alu_op    = ALU_ADD;
            end
            CLS_AUIPC: begin
                s.alu_a_sel = 1'b1;
                s.alu_b_sel = 1'b1;
                s.alu_op    = ALU_ADD;
            end
            CLS_LUI: begin
                s.alu_b_sel = 1'b1;
                s.alu_op    = ALU_PASSB;
            end
            CLS_BRANCH: begin
                s.alu_op    = ALU_CMP;
            end
            default: begin
                // JAL does not use the ALU: leave everything at zero
                s.alu_op    = ALU_ADD;
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm_if
// Instruction/data memory handshake bundle between the control FSM and the
// memory side.
//   imem_req  : instruction fetch request          (controller -> memory)
//   imem_ack  : instruction accepted/returned      (memory -> controller)
//   dmem_req  : data access request                (controller -> memory)
//   dmem_we   : 1 = store, 0 = load, with dmem_req (controller -> memory)
//   dmem_ack  : data access done                   (memory -> controller)
// -----------------------------------------------------------------------------
interface mc_ctrl_fsm_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req,
        input  imem_ack,
        output dmem_req,
        output dmem_we,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        input  dmem_req,
        input  dmem_we,
        output dmem_ack
    );
endinterface

// File: rtl/mc_ctrl_fsm_decode.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm_decode
// Combinational opcode classifier.
//   opcode  in  7  instr[6:0]
//   cls     out    instruction class (CLS_OP when the opcode is illegal)
//   illegal out 1  opcode is not one of the nine RV32I base classes handled
// -----------------------------------------------------------------------------
module mc_ctrl_fsm_decode
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [6:0] opcode,
    output class_t     cls,
    output logic       illegal
);

    // Opcode to class lookup
    always_comb begin
        cls     = CLS_OP;
        illegal = 1'b0;
        case (opcode)
            OPC_OP:     cls = CLS_OP;
            OPC_OPIMM:  cls = CLS_OPIMM;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_LUI:    cls = CLS_LUI;
            OPC_AUIPC:  cls = CLS_AUIPC;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            default: begin
                cls     = CLS_OP;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
// Multi-cycle control FSM for the RV32I core. Sequences
// IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, drives the datapath
// mux selects and enables, runs the imem/dmem req/ack handshakes and traps on an
// illegal opcode or a handshake timeout.
// Parameters:
//   TIMEOUT    cycles a request may wait for its ack (0 = wait forever)
//   INSTRET_W  width of the retired-instruction counter
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   opcode          instr[6:0] from the IR, stable from DECODE onward
//   br_taken        branch compare result, valid in EXEC
//   bus             memory handshake bundle (master side)
//   ir_we           IR load pulse (the cycle after the fetch ack)
//   pc_we, pc_sel   PC update enable / next-PC source
//   alu_a_sel, alu_b_sel, alu_op   ALU operand and operation selects
//   rf_we, wb_sel   register-file write enable / writeback source
//   illegal, bus_err  sticky trap causes
//   instret         retired instruction count (one per pc_we cycle)
// -----------------------------------------------------------------------------
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int TIMEOUT   = 16,
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 br_taken,
    mc_ctrl_fsm_if.master        bus,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 alu_a_sel,
    output logic                 alu_b_sel,
    output logic [1:0]           alu_op,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [INSTRET_W-1:0] instret
);

    // The counter only ever needs to hold TIMEOUT-1
    localparam int                 CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int                 TO_LAST   = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0]   TO_LAST_C = CNT_W'(TO_LAST);

    state_t                 state_r;
    class_t                 cls_r;
    logic [CNT_W-1:0]       to_cnt_r;
    logic [INSTRET_W-1:0]   instret_r;

    logic                   imem_req_r;
    logic                   dmem_req_r;
    logic                   dmem_we_r;
    logic                   ir_we_r;
    logic                   pc_we_r;
    logic [1:0]             pc_sel_r;
    logic                   alu_a_sel_r;
    logic                   alu_b_sel_r;
    logic [1:0]             alu_op_r;
    logic                   rf_we_r;
    logic [1:0]             wb_sel_r;
    logic                   illegal_r;
    logic                   bus_err_r;

    class_t                 dec_cls_s;
    logic                   dec_illegal_s;
    logic                   imem_ack_s;
    logic                   dmem_ack_s;
    logic                   to_hit_s;
    logic                   store_ack_s;
    logic                   br_exec_s;
    logic                   pc_we_s;

    state_t                 nxt_state_s;
    class_t                 nxt_cls_s;
    logic                   set_illegal_s;
    logic                   set_bus_err_s;
    sel_t                   nxt_sel_s;

    logic                   n_imem_req_s;
    logic                   n_dmem_req_s;
    logic                   n_dmem_we_s;
    logic                   n_ir_we_s;
    logic                   n_pc_we_s;
    logic [1:0]             n_pc_sel_s;
    logic                   n_alu_a_sel_s;
    logic                   n_alu_b_sel_s;
    logic [1:0]             n_alu_op_s;
    logic                   n_rf_we_s;
    logic [1:0]             n_wb_sel_s;

    mc_ctrl_fsm_decode u_decode (
        .opcode  (opcode),
        .cls     (dec_cls_s),
        .illegal (dec_illegal_s)
    );

    // An ack only counts while our own request is up
    assign imem_ack_s  = bus.imem_ack & imem_req_r;
    assign dmem_ack_s  = bus.dmem_ack & dmem_req_r;
    assign to_hit_s    = (TIMEOUT != 0) && (to_cnt_r == TO_LAST_C);

    // Two strobes have to react inside the current cycle: a store retires
    // (pc_we) on its ack cycle, and a branch picks its target from br_taken,
    // which only becomes valid in EXEC. Everything else is registered.
    assign store_ack_s = (state_r == MEM) && (cls_r == CLS_STORE) && dmem_ack_s;
    assign br_exec_s   = (state_r == EXEC) && (cls_r == CLS_BRANCH);
    assign pc_we_s     = pc_we_r | store_ack_s;

    // Next-state and trap-cause decode
    always_comb begin
        nxt_state_s   = state_r;
        nxt_cls_s     = cls_r;
        set_illegal_s = 1'b0;
        set_bus_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                nxt_state_s = FETCH;
            end
            FETCH: begin
                // ack on the last allowed cycle still wins over the timeout
                if (imem_ack_s) begin
                    nxt_state_s = DECODE;
                end else if (to_hit_s) begin
                    nxt_state_s   = TRAP;
                    set_bus_err_s = 1'b1;
                end else begin
                    nxt_state_s = FETCH;
                end
            end
            DECODE: begin
                nxt_cls_s = dec_cls_s;
                if (dec_illegal_s) begin
                    nxt_state_s   = TRAP;
                    set_illegal_s = 1'b1;
                end else begin
                    nxt_state_s = EXEC;
                end
            end
            EXEC: begin
                case (cls_r)
                    CLS_BRANCH:          nxt_state_s = FETCH;
                    CLS_LOAD, CLS_STORE: nxt_state_s = MEM;
                    default:             nxt_state_s = WB;
                endcase
            end
            MEM: begin
                if (dmem_ack_s) begin
                    if (cls_r == CLS_STORE) begin
                        nxt_state_s = FETCH;
                    end else begin
                        nxt_state_s = WB;
                    end
                end else if (to_hit_s) begin
                    nxt_state_s   = TRAP;
                    set_bus_err_s = 1'b1;
                end else begin
                    nxt_state_s = MEM;
                end
            end
            WB: begin
                nxt_state_s = FETCH;
            end
            TRAP: begin
                nxt_state_s = TRAP;
            end
            default: begin
                nxt_state_s = TRAP;
            end
        endcase
    end

    assign nxt_sel_s = exec_sel(nxt_cls_s);

    // Output values for the state being entered; registered below
    always_comb begin
        n_imem_req_s  = 1'b0;
        n_dmem_req_s  = 1'b0;
        n_dmem_we_s   = 1'b0;
        n_ir_we_s     = 1'b0;
        n_pc_we_s     = 1'b0;
        n_pc_sel_s    = PC_PLUS4;
        n_alu_a_sel_s = 1'b0;
        n_alu_b_sel_s = 1'b0;
        n_alu_op_s    = ALU_ADD;
        n_rf_we_s     = 1'b0;
        n_wb_sel_s    = WB_ALU;
        case (nxt_state_s)
            FETCH: begin
                n_imem_req_s = 1'b1;
            end
            DECODE: begin
                n_ir_we_s = 1'b1;
            end
            EXEC: begin
                n_alu_a_sel_s = nxt_sel_s.alu_a_sel;
                n_alu_b_sel_s = nxt_sel_s.alu_b_sel;
                n_alu_op_s    = nxt_sel_s.alu_op;
                // branch target choice is muxed in from br_taken during EXEC
                if (nxt_cls_s == CLS_BRANCH) begin
                    n_pc_we_s = 1'b1;
                end else begin
                    n_pc_we_s = 1'b0;
                end
            end
            MEM: begin
                n_alu_a_sel_s = nxt_sel_s.alu_a_sel;
                n_alu_b_sel_s = nxt_sel_s.alu_b_sel;
                n_alu_op_s    = nxt_sel_s.alu_op;
                n_dmem_req_s  = 1'b1;
                n_dmem_we_s   = (nxt_cls_s == CLS_STORE);
            end
            WB: begin
                n_alu_a_sel_s = nxt_sel_s.alu_a_sel;
                n_alu_b_sel_s = nxt_sel_s.alu_b_sel;
                n_alu_op_s    = nxt_sel_s.alu_op;
                n_rf_we_s     = 1'b1;
                n_pc_we_s     = 1'b1;
                case (nxt_cls_s)
                    CLS_LOAD:          n_wb_sel_s = WB_MEM;
                    CLS_JAL, CLS_JALR: n_wb_sel_s = WB_PC4;
                    default:           n_wb_sel_s = WB_ALU;
                endcase
                case (nxt_cls_s)
                    CLS_JAL:  n_pc_sel_s = PC_IMM;
                    CLS_JALR: n_pc_sel_s = PC_ALU;
                    default:  n_pc_sel_s = PC_PLUS4;
                endcase
            end
            default: begin
                // IDLE and TRAP: every strobe stays low
                n_imem_req_s = 1'b0;
            end
        endcase
    end

    // State, class, timeout counter, retirement counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cls_r       <= CLS_OP;
            to_cnt_r    <= {CNT_W{1'b0}};
            instret_r   <= {INSTRET_W{1'b0}};
            imem_req_r  <= 1'b0;
            dmem_req_r  <= 1'b0;
            dmem_we_r   <= 1'b0;
            ir_we_r     <= 1'b0;
            pc_we_r     <= 1'b0;
            pc_sel_r    <= 2'd0;
            alu_a_sel_r <= 1'b0;
            alu_b_sel_r <= 1'b0;
            alu_op_r    <= 2'd0;
            rf_we_r     <= 1'b0;
            wb_sel_r    <= 2'd0;
            illegal_r   <= 1'b0;
            bus_err_r   <= 1'b0;
        end else begin
            state_r     <= nxt_state_s;
            cls_r       <= nxt_cls_s;
            imem_req_r  <= n_imem_req_s;
            dmem_req_r  <= n_dmem_req_s;
            dmem_we_r   <= n_dmem_we_s;
            ir_we_r     <= n_ir_we_s;
            pc_we_r     <= n_pc_we_s;
            pc_sel_r    <= n_pc_sel_s;
            alu_a_sel_r <= n_alu_a_sel_s;
            alu_b_sel_r <= n_alu_b_sel_s;
            alu_op_r    <= n_alu_op_s;
            rf_we_r     <= n_rf_we_s;
            wb_sel_r    <= n_wb_sel_s;
            illegal_r   <= illegal_r | set_illegal_s;
            bus_err_r   <= bus_err_r | set_bus_err_s;

            // restart the wait count whenever a new request phase begins
            if ((nxt_state_s != state_r) &&
                ((nxt_state_s == FETCH) || (nxt_state_s == MEM))) begin
                to_cnt_r <= {CNT_W{1'b0}};
            end else if ((state_r == FETCH) || (state_r == MEM)) begin
                to_cnt_r <= to_cnt_r + CNT_W'(1'b1);
            end else begin
                to_cnt_r <= to_cnt_r;
            end

            if (pc_we_s) begin
                instret_r <= instret_r + INSTRET_W'(1'b1);
            end else begin
                instret_r <= instret_r;
            end
        end
    end

    assign bus.imem_req = imem_req_r;
    assign bus.dmem_req = dmem_req_r;
    assign bus.dmem_we  = dmem_we_r;
    assign ir_we        = ir_we_r;
    assign pc_we        = pc_we_s;
    assign pc_sel       = br_exec_s ? {1'b0, br_taken} : pc_sel_r;
    assign alu_a_sel    = alu_a_sel_r;
    assign alu_b_sel    = alu_b_sel_r;
    assign alu_op       = alu_op_r;
    assign rf_we        = rf_we_r;
    assign wb_sel       = wb_sel_r;
    assign illegal      = illegal_r;
    assign bus_err      = bus_err_r;
    assign instret      = instret_r;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Directed bench for mc_ctrl_fsm (TIMEOUT=8, INSTRET_W=4 so the retirement
// counter wraps within the run). Inputs change 1 time unit after a rising
// edge; outputs are sampled 2 units after it.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       br_taken;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] alu_op;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       illegal;
    logic       bus_err;
    logic [3:0] instret;

    mc_ctrl_fsm_if bus_if ();

    mc_ctrl_fsm #(
        .TIMEOUT   (8),
        .INSTRET_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .br_taken  (br_taken),
        .bus       (bus_if),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .alu_a_sel (alu_a_sel),
        .alu_b_sel (alu_b_sel),
        .alu_op    (alu_op),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .illegal   (illegal),
        .bus_err   (bus_err),
        .instret   (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] opc;
        logic       brt;
        logic       ex_a;
        logic       ex_b;
        logic [1:0] ex_op;
        logic       ex_pc_we;
        logic [1:0] ex_pc_sel;
        logic       has_mem;
        logic       mem_we;
        logic       mem_pc_we;
        logic       has_wb;
        logic [1:0] wb_sel;
        logic [1:0] wb_pc_sel;
    } vec_t;

    vec_t       vecs [10];
    int         n_vec;
    int         n_err;
    logic [3:0] exp_instret;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT at the start of its first FETCH cycle
    task automatic do_reset();
        rst             = 1'b1;
        bus_if.imem_ack = 1'b0;
        bus_if.dmem_ack = 1'b0;
        cyc();
        cyc();
        rst         = 1'b0;
        exp_instret = 4'd0;
        #1;
        chk("idle_imem_req", bus_if.imem_req, 32'd0);
        cyc();
    endtask

    // One instruction with every ack in its first request cycle
    task automatic run_vec(input int i, input vec_t v);
        // FETCH
        bus_if.imem_ack = 1'b1;
        bus_if.dmem_ack = 1'b0;
        opcode          = v.opc;
        br_taken        = v.brt;
        #1;
        chk($sformatf("v%0d_fetch_req", i), bus_if.imem_req, 32'd1);
        chk($sformatf("v%0d_fetch_rf_we", i), rf_we, 32'd0);
        chk($sformatf("v%0d_fetch_instret", i), instret, exp_instret);
        cyc();
        // DECODE
        bus_if.imem_ack = 1'b0;
        #1;
        chk($sformatf("v%0d_dec_ir_we", i), ir_we, 32'd1);
        chk($sformatf("v%0d_dec_req_low", i), bus_if.imem_req, 32'd0);
        cyc();
        // EXEC
        #1;
        chk($sformatf("v%0d_ex_a", i), alu_a_sel, v.ex_a);
        chk($sformatf("v%0d_ex_b", i), alu_b_sel, v.ex_b);
        chk($sformatf("v%0d_ex_op", i), alu_op, v.ex_op);
        chk($sformatf("v%0d_ex_pc_we", i), pc_we, v.ex_pc_we);
        chk($sformatf("v%0d_ex_pc_sel", i), pc_sel, v.ex_pc_sel);
        chk($sformatf("v%0d_ex_rf_we", i), rf_we, 32'd0);
        chk($sformatf("v%0d_ex_instret", i), instret, exp_instret);
        cyc();
        if (v.has_mem) begin
            bus_if.dmem_ack = 1'b1;
            #1;
            chk($sformatf("v%0d_mem_req", i), bus_if.dmem_req, 32'd1);
            chk($sformatf("v%0d_mem_we", i), bus_if.dmem_we, v.mem_we);
            chk($sformatf("v%0d_mem_pc_we", i), pc_we, v.mem_pc_we);
            chk($sformatf("v%0d_mem_pc_sel", i), pc_sel, 32'd0);
            chk($sformatf("v%0d_mem_b_hold", i), alu_b_sel, v.ex_b);
            chk($sformatf("v%0d_mem_rf_we", i), rf_we, 32'd0);
            cyc();
            bus_if.dmem_ack = 1'b0;
        end
        if (v.has_wb) begin
            #1;
            chk($sformatf("v%0d_wb_rf_we", i), rf_we, 32'd1);
            chk($sformatf("v%0d_wb_pc_we", i), pc_we, 32'd1);
            chk($sformatf("v%0d_wb_sel", i), wb_sel, v.wb_sel);
            chk($sformatf("v%0d_wb_pc_sel", i), pc_sel, v.wb_pc_sel);
            chk($sformatf("v%0d_wb_op_hold", i), alu_op, v.ex_op);
            chk($sformatf("v%0d_wb_a_hold", i), alu_a_sel, v.ex_a);
            chk($sformatf("v%0d_wb_dmem_req", i), bus_if.dmem_req, 32'd0);
            cyc();
        end
        exp_instret = exp_instret + 4'd1;
    endtask

    initial begin
        n_vec           = 0;
        n_err           = 0;
        exp_instret     = 4'd0;
        rst             = 1'b0;
        opcode          = 7'd0;
        br_taken        = 1'b0;
        bus_if.imem_ack = 1'b0;
        bus_if.dmem_ack = 1'b0;

        //            opc          brt   a     b     op    ex_we ex_sel mem   m_we  m_pcw wb    wb_sel wb_pc
        vecs[0] = '{7'b0010011, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0}; // OPIMM
        vecs[1] = '{7'b0110011, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0}; // OP
        vecs[2] = '{7'b0110111, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0}; // LUI
        vecs[3] = '{7'b0010111, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0}; // AUIPC
        vecs[4] = '{7'b1101111, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1}; // JAL
        vecs[5] = '{7'b1100111, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2}; // JALR
        vecs[6] = '{7'b1100011, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}; // BRANCH taken
        vecs[7] = '{7'b1100011, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}; // BRANCH not taken
        vecs[8] = '{7'b0000011, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0}; // LOAD
        vecs[9] = '{7'b0100011, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0}; // STORE

        // Reset values, checked before any clock edge
        #1;
        rst = 1'b1;
        #1;
        chk("rst_imem_req", bus_if.imem_req, 32'd0);
        chk("rst_dmem_req", bus_if.dmem_req, 32'd0);
        chk("rst_dmem_we", bus_if.dmem_we, 32'd0);
        chk("rst_ir_we", ir_we, 32'd0);
        chk("rst_pc_we", pc_we, 32'd0);
        chk("rst_pc_sel", pc_sel, 32'd0);
        chk("rst_alu_op", alu_op, 32'd0);
        chk("rst_rf_we", rf_we, 32'd0);
        chk("rst_wb_sel", wb_sel, 32'd0);
        chk("rst_illegal", illegal, 32'd0);
        chk("rst_bus_err", bus_err, 32'd0);
        chk("rst_instret", instret, 32'd0);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i]);
        end

        // LOAD with stray dmem_ack before MEM and the real ack 3 cycles late
        bus_if.imem_ack = 1'b1;
        opcode          = 7'b0000011;
        #1;
        chk("late_fetch_req", bus_if.imem_req, 32'd1);
        cyc();
        bus_if.imem_ack = 1'b0;
        bus_if.dmem_ack = 1'b1;
        #1;
        chk("stray_dec_dmem_req", bus_if.dmem_req, 32'd0);
        cyc();
        #1;
        chk("stray_ex_dmem_req", bus_if.dmem_req, 32'd0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            bus_if.dmem_ack = (k == 3);
            #1;
            chk($sformatf("late_dmem_req_%0d", k), bus_if.dmem_req, 32'd1);
            chk($sformatf("late_dmem_we_%0d", k), bus_if.dmem_we, 32'd0);
            chk($sformatf("late_pc_we_%0d", k), pc_we, 32'd0);
            cyc();
        end
        bus_if.dmem_ack = 1'b0;
        #1;
        chk("late_wb_rf_we", rf_we, 32'd1);
        chk("late_wb_sel", wb_sel, 32'd1);
        chk("late_wb_dmem_req", bus_if.dmem_req, 32'd0);
        cyc();
        exp_instret = exp_instret + 4'd1;

        // Six more retirements push the 4-bit counter past 15
        for (int i = 0; i < 6; i++) begin
            run_vec(20 + i, vecs[0]);
        end
        #1;
        chk("wrap_instret", instret, exp_instret);
        chk("wrap_fetch_req", bus_if.imem_req, 32'd1);

        // Illegal opcode: trap and never fetch again
        do_reset();
        bus_if.imem_ack = 1'b1;
        opcode          = 7'b0000000;
        #1;
        cyc();
        bus_if.imem_ack = 1'b0;
        #1;
        chk("ill_dec_illegal", illegal, 32'd0);
        cyc();
        for (int k = 0; k < 20; k++) begin
            bus_if.imem_ack = 1'b1;
            #1;
            chk($sformatf("ill_imem_req_%0d", k), bus_if.imem_req, 32'd0);
            chk($sformatf("ill_flag_%0d", k), illegal, 32'd1);
            cyc();
        end
        chk("ill_bus_err", bus_err, 32'd0);
        chk("ill_instret", instret, 32'd0);

        // Fetch timeout: no ack for 8 request cycles
        do_reset();
        for (int k = 0; k < 8; k++) begin
            bus_if.imem_ack = 1'b0;
            #1;
            chk($sformatf("to_req_%0d", k), bus_if.imem_req, 32'd1);
            chk($sformatf("to_berr_pre_%0d", k), bus_err, 32'd0);
            cyc();
        end
        #1;
        chk("to_bus_err", bus_err, 32'd1);
        chk("to_req_drop", bus_if.imem_req, 32'd0);
        chk("to_illegal", illegal, 32'd0);
        cyc();
        #1;
        chk("to_bus_err_sticky", bus_err, 32'd1);

        // Ack on the 8th request cycle wins over the timeout
        do_reset();
        opcode = 7'b0010011;
        for (int k = 0; k < 8; k++) begin
            bus_if.imem_ack = (k == 7);
            #1;
            chk($sformatf("to8_req_%0d", k), bus_if.imem_req, 32'd1);
            cyc();
        end
        bus_if.imem_ack = 1'b0;
        #1;
        chk("to8_ir_we", ir_we, 32'd1);
        chk("to8_bus_err", bus_err, 32'd0);
        cyc();
        cyc();
        #1;
        chk("to8_wb_rf_we", rf_we, 32'd1);
        cyc();
        #1;
        chk("to8_b2b_fetch", bus_if.imem_req, 32'd1);
        chk("to8_instret", instret, 32'd1);
        chk("to8_bus_err_end", bus_err, 32'd0);

        // Reset asserted in the middle of a MEM cycle
        do_reset();
        run_vec(30, vecs[0]);
        bus_if.imem_ack = 1'b1;
        opcode          = 7'b0000011;
        cyc();
        bus_if.imem_ack = 1'b0;
        cyc();
        cyc();
        #1;
        chk("rm_dmem_req_pre", bus_if.dmem_req, 32'd1);
        chk("rm_instret_pre", instret, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rm_dmem_req_async", bus_if.dmem_req, 32'd0);
        chk("rm_instret", instret, 32'd0);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rm_idle_req", bus_if.imem_req, 32'd0);
        cyc();
        #1;
        chk("rm_fetch_resume", bus_if.imem_req, 32'd1);
        chk("rm_instret_post", instret, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
